// File: rtl/bcd_time_display_mux.sv
// bcd_time_display_mux
//   Drives a 6-digit multiplexed seven-segment display from the BCD outputs
//   of the 12-hour clock. All six digits are copied into shadow registers once
//   per frame, so one frame never shows a mix of old and new digits. Each digit
//   gets one slot of REFRESH_DIV cycles. The first BLANK_CYCLES cycles of every
//   slot keep all anodes off to suppress ghosting. A leading zero in the hour
//   tens is not shown. The decimal points on digits 2 and 4 blink as a separator.
//
// Parameters
//   REFRESH_DIV   clk cycles per digit slot (>= 2)
//   BLANK_CYCLES  anode-off cycles at the start of each slot (1 .. REFRESH_DIV-1)
//   ACTIVE_LOW    1 inverts seg, dp and an at the pins (common-anode boards)
//
// Ports
//   clk          system clock
//   reset        asynchronous, active-high reset
//   en           scan enable; low holds the scan position and blanks the display
//   sec_units .. hour_tens   BCD digits from the clock (hour_tens is 0/1)
//   seg          segments {g,f,e,d,c,b,a}, logical 1 = lit
//   dp           decimal point, logical 1 = lit
//   an           one-hot digit enable, bit0 = sec_units .. bit5 = hour_tens
//   frame_start  one-cycle pulse in the cycle after a snapshot is taken
module bcd_time_display_mux #(
  parameter int REFRESH_DIV  = 1000,
  parameter int BLANK_CYCLES = 16,
  parameter bit ACTIVE_LOW   = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic [3:0] sec_units,
  input  logic [3:0] sec_tens,
  input  logic [3:0] min_units,
  input  logic [3:0] min_tens,
  input  logic [3:0] hour_units,
  input  logic [1:0] hour_tens,
  output logic [6:0] seg,
  output logic       dp,
  output logic [5:0] an,
  output logic       frame_start
);

  localparam int PW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [PW-1:0] LAST_COUNT = PW'(REFRESH_DIV - 1);
  localparam logic [PW-1:0] BLANK_END  = PW'(BLANK_CYCLES);

  logic [PW-1:0] prescaler;
  logic [2:0]    idx;
  logic [3:0]    shadow [6];
  logic          snapshot;

  logic [3:0]    cur_digit;
  logic [6:0]    seg_next;
  logic          dp_next;
  logic [5:0]    an_next;

  logic [6:0]    seg_q;
  logic          dp_q;
  logic [5:0]    an_q;

  // A frame begins at the first cycle of slot 0. Only then are the inputs
  // sampled.
  assign snapshot = en && (prescaler == '0) && (idx == 3'd0);

  // Slot timing. When en is low, both counters hold so that the scan resumes
  // exactly where it stopped.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prescaler <= '0;
      idx       <= 3'd0;
    end else if (en) begin
      if (prescaler == LAST_COUNT) begin
        prescaler <= '0;
        idx       <= (idx == 3'd5) ? 3'd0 : idx + 3'd1;
      end else begin
        prescaler <= prescaler + 1'b1;
      end
    end
  end

  // Shadow copy of the digits, plus the frame_start pulse that marks it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 6; i++) shadow[i] <= 4'd0;
      frame_start <= 1'b0;
    end else begin
      frame_start <= snapshot;
      if (snapshot) begin
        shadow[0] <= sec_units;
        shadow[1] <= sec_tens;
        shadow[2] <= min_units;
        shadow[3] <= min_tens;
        shadow[4] <= hour_units;
        shadow[5] <= {2'b00, hour_tens};
      end
    end
  end

  // Select the shadow digit for the current slot.
  always_comb begin
    cur_digit = 4'd0;
    case (idx)
      3'd0:    cur_digit = shadow[0];
      3'd1:    cur_digit = shadow[1];
      3'd2:    cur_digit = shadow[2];
      3'd3:    cur_digit = shadow[3];
      3'd4:    cur_digit = shadow[4];
      3'd5:    cur_digit = shadow[5];
      default: cur_digit = 4'd0;
    endcase
  end

  // Seven-segment decode. Any non-BCD value shows a dash, so a bad
  // upstream digit is visible on the display.
  always_comb begin
    seg_next = 7'b1000000;
    case (cur_digit)
      4'd0:    seg_next = 7'b0111111;
      4'd1:    seg_next = 7'b0000110;
      4'd2:    seg_next = 7'b1011011;
      4'd3:    seg_next = 7'b1001111;
      4'd4:    seg_next = 7'b1100110;
      4'd5:    seg_next = 7'b1101101;
      4'd6:    seg_next = 7'b1111101;
      4'd7:    seg_next = 7'b0000111;
      4'd8:    seg_next = 7'b1111111;
      4'd9:    seg_next = 7'b1101111;
      default: seg_next = 7'b1000000;
    endcase
  end

  // Anodes stay off in these cases: the scan is disabled, the slot is in its
  // blanking gap, or the slot is a suppressed zero in the hour tens. The
  // separator blinks on the even seconds.
  always_comb begin
    an_next = 6'b000000;
    if (en && (prescaler >= BLANK_END) && (idx <= 3'd5) &&
        !((idx == 3'd5) && (shadow[5] == 4'd0)))
      an_next = 6'b000001 << idx;
    dp_next = en && ((idx == 3'd2) || (idx == 3'd4)) && !shadow[0][0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      seg_q <= 7'd0;
      dp_q  <= 1'b0;
      an_q  <= 6'd0;
    end else begin
      seg_q <= seg_next;
      dp_q  <= dp_next;
      an_q  <= an_next;
    end
  end

  // Pin polarity is applied after the register. It never affects frame_start.
  assign seg = seg_q ^ {7{ACTIVE_LOW}};
  assign dp  = dp_q ^ ACTIVE_LOW;
  assign an  = an_q ^ {6{ACTIVE_LOW}};

endmodule

// File: tb/tb_bcd_time_display_mux.sv
// tb_bcd_time_display_mux
//   Self-checking bench for bcd_time_display_mux with REFRESH_DIV=8 and
//   BLANK_CYCLES=2. Two instances are built, active-high and active-low, and
//   both share the same stimulus. The reference model follows the display as a
//   position inside a 48-cycle frame: slot = pos/8 and offset in slot = pos%8.
//   It also keeps its own copy of the digits that were latched at pos 0.
module tb_bcd_time_display_mux;

  localparam int RD    = 8;
  localparam int BC    = 2;
  localparam int FRAME = 6 * RD;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       en = 1'b1;
  logic [3:0] sec_units = 4'd6, sec_tens = 4'd5, min_units = 4'd4;
  logic [3:0] min_tens = 4'd3, hour_units = 4'd2;
  logic [1:0] hour_tens = 2'd1;

  logic [6:0] seg, seg_n;
  logic       dp, dp_n, fs, fs_n;
  logic [5:0] an, an_n;

  int checks = 0;
  int errors = 0;

  // reference model state
  int         m_pos;
  int         m_shadow [6];
  logic [6:0] seg_table [16];
  logic [6:0] exp_seg;
  logic       exp_dp, exp_fs;
  logic [5:0] exp_an;

  bcd_time_display_mux #(.REFRESH_DIV(RD), .BLANK_CYCLES(BC), .ACTIVE_LOW(1'b0)) u_dut (
    .clk(clk), .reset(reset), .en(en),
    .sec_units(sec_units), .sec_tens(sec_tens), .min_units(min_units),
    .min_tens(min_tens), .hour_units(hour_units), .hour_tens(hour_tens),
    .seg(seg), .dp(dp), .an(an), .frame_start(fs));

  bcd_time_display_mux #(.REFRESH_DIV(RD), .BLANK_CYCLES(BC), .ACTIVE_LOW(1'b1)) u_dut_n (
    .clk(clk), .reset(reset), .en(en),
    .sec_units(sec_units), .sec_tens(sec_tens), .min_units(min_units),
    .min_tens(min_tens), .hour_units(hour_units), .hour_tens(hour_tens),
    .seg(seg_n), .dp(dp_n), .an(an_n), .frame_start(fs_n));

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not finish, got timeout required finish");
    $fatal(1, "[TB] watchdog");
  end

  task automatic model_reset();
    m_pos = 0;
    for (int i = 0; i < 6; i++) m_shadow[i] = 0;
    exp_seg = 7'd0;
    exp_dp  = 1'b0;
    exp_an  = 6'd0;
    exp_fs  = 1'b0;
  endtask

  // One clock edge. Afterwards, exp_* holds what the pins show until the next
  // edge. The DUT is sampled 1 time unit after the edge.
  task automatic tick();
    int slot, phase;
    @(posedge clk);
    if (reset) begin
      model_reset();
    end else begin
      slot    = m_pos / RD;
      phase   = m_pos % RD;
      exp_seg = seg_table[m_shadow[slot]];
      exp_dp  = en && (slot == 2 || slot == 4) && (m_shadow[0] % 2 == 0);
      exp_an  = (en && phase >= BC && !(slot == 5 && m_shadow[5] == 0)) ? 6'(1 << slot) : 6'd0;
      exp_fs  = en && (m_pos == 0);
      if (en && m_pos == 0) begin
        m_shadow[0] = int'(sec_units);
        m_shadow[1] = int'(sec_tens);
        m_shadow[2] = int'(min_units);
        m_shadow[3] = int'(min_tens);
        m_shadow[4] = int'(hour_units);
        m_shadow[5] = int'(hour_tens);
      end
      if (en) m_pos = (m_pos + 1) % FRAME;
    end
    #1;
  endtask

  task automatic go_to(input int p);
    for (int i = 0; i < 4 * FRAME && m_pos != p; i++) tick();
  endtask

  task automatic test_reset();
    int pulses;
    reset = 1'b1;
    en    = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({seg, dp, an, fs} !== 15'd0 || {seg_n, dp_n, an_n} !== 14'h3fff || fs_n !== 1'b0) begin
        errors++;
        $display("FAIL reset_state got seg=%b dp=%b an=%b fs=%b inv=%b/%b/%b required all off",
                 seg, dp, an, fs, seg_n, dp_n, an_n);
      end
    end
    reset  = 1'b0;
    pulses = 0;
    for (int i = 1; i <= 6; i++) begin
      tick();
      if (fs) pulses++;
      checks++;
      if (fs !== (i == 1)) begin
        errors++;
        $display("FAIL reset_first_frame cycle %0d got fs=%b required %b", i, fs, (i == 1));
      end
    end
    checks++;
    if (pulses != 1) begin
      errors++;
      $display("FAIL reset_pulse_count got %0d required 1", pulses);
    end
  endtask

  task automatic test_scan();
    logic [6:0] want [6];
    int t_first, t_second;
    want[0] = 7'b1111101; want[1] = 7'b1101101; want[2] = 7'b1100110;
    want[3] = 7'b1001111; want[4] = 7'b1011011; want[5] = 7'b0000110;
    t_first = -1; t_second = -1;
    for (int t = 0; t < 2 * FRAME; t++) begin
      tick();
      checks++;
      if ({seg, dp, an, fs} !== {exp_seg, exp_dp, exp_an, exp_fs} ||
          {seg_n, dp_n, an_n} !== ~{exp_seg, exp_dp, exp_an} || fs_n !== exp_fs) begin
        errors++;
        $display("FAIL scan pos=%0d got seg=%b dp=%b an=%b fs=%b inv=%b/%b/%b required seg=%b dp=%b an=%b fs=%b",
                 m_pos, seg, dp, an, fs, seg_n, dp_n, an_n, exp_seg, exp_dp, exp_an, exp_fs);
      end
      for (int k = 0; k < 6; k++) begin
        if (an == 6'(1 << k)) begin
          checks++;
          if (seg !== want[k]) begin
            errors++;
            $display("FAIL scan_digit slot %0d got seg=%b required %b", k, seg, want[k]);
          end
        end
      end
      if (fs) begin
        if (t_first < 0) t_first = t;
        else if (t_second < 0) t_second = t;
      end
    end
    checks++;
    if (t_first < 0 || t_second - t_first != FRAME) begin
      errors++;
      $display("FAIL scan_frame_period got %0d required %0d", t_second - t_first, FRAME);
    end
  endtask

  task automatic test_leading_zero();
    int pulses;
    bit an5_seen, an4_ok;
    hour_tens = 2'd0; hour_units = 4'd9;
    for (int i = 0; i < 2 * FRAME && !fs; i++) tick();
    checks++;
    if (!fs) begin
      errors++;
      $display("FAIL lz_wait_frame got fs=%b required 1", fs);
    end
    pulses = 0; an5_seen = 0; an4_ok = 0;
    for (int t = 0; t < 3 * FRAME; t++) begin
      tick();
      checks++;
      if ({seg, dp, an, fs} !== {exp_seg, exp_dp, exp_an, exp_fs} ||
          {seg_n, dp_n, an_n} !== ~{exp_seg, exp_dp, exp_an}) begin
        errors++;
        $display("FAIL lz pos=%0d got seg=%b dp=%b an=%b fs=%b required seg=%b dp=%b an=%b fs=%b",
                 m_pos, seg, dp, an, fs, exp_seg, exp_dp, exp_an, exp_fs);
      end
      if (an[5]) an5_seen = 1;
      if (an == 6'b010000 && seg == 7'b1101111 && dp) an4_ok = 1;
      if (fs) pulses++;
    end
    checks++;
    if (an5_seen) begin
      errors++;
      $display("FAIL lz_an5 got an[5] lit required never lit");
    end
    checks++;
    if (!an4_ok) begin
      errors++;
      $display("FAIL lz_an4 got no an4 with seg=1101111 dp=1 required seen");
    end
    checks++;
    if (pulses != 3) begin
      errors++;
      $display("FAIL lz_frames got %0d pulses required 3", pulses);
    end
  endtask

  task automatic test_tearing();
    int frame;
    int seen;
    hour_tens = 2'd1; hour_units = 4'd2; min_units = 4'd4;
    go_to(0);
    go_to(RD + 3);
    min_units = 4'd5;
    frame = 0; seen = 0;
    for (int t = 0; t < FRAME + 37; t++) begin
      tick();
      if (fs) frame++;
      checks++;
      if ({seg, dp, an, fs} !== {exp_seg, exp_dp, exp_an, exp_fs}) begin
        errors++;
        $display("FAIL tearing pos=%0d got seg=%b dp=%b an=%b fs=%b required seg=%b dp=%b an=%b fs=%b",
                 m_pos, seg, dp, an, fs, exp_seg, exp_dp, exp_an, exp_fs);
      end
      if (an == 6'b000100) begin
        seen++;
        checks++;
        if (seg !== ((frame == 0) ? 7'b1100110 : 7'b1101101)) begin
          errors++;
          $display("FAIL tearing_slot2 frame %0d got seg=%b required %b", frame, seg,
                   (frame == 0) ? 7'b1100110 : 7'b1101101);
        end
      end
    end
    checks++;
    if (seen != 2 * (RD - BC)) begin
      errors++;
      $display("FAIL tearing_slot2_count got %0d required %0d", seen, 2 * (RD - BC));
    end
  endtask

  task automatic test_invalid();
    int seen;
    min_tens = 4'hA;
    go_to(1);
    seen = 0;
    for (int t = 0; t < FRAME; t++) begin
      tick();
      checks++;
      if ({seg, dp, an, fs} !== {exp_seg, exp_dp, exp_an, exp_fs}) begin
        errors++;
        $display("FAIL invalid pos=%0d got seg=%b an=%b required seg=%b an=%b", m_pos, seg, an, exp_seg, exp_an);
      end
      if (an == 6'b001000) begin
        seen++;
        checks++;
        if (seg !== 7'b1000000) begin
          errors++;
          $display("FAIL invalid_dash got seg=%b required 1000000", seg);
        end
      end
    end
    checks++;
    if (seen == 0) begin
      errors++;
      $display("FAIL invalid_slot3 got an=001000 never required seen");
    end
    min_tens = 4'd3;
  endtask

  task automatic test_enable();
    int held, remaining;
    go_to(RD + 4);
    held = m_pos;
    en = 1'b0;
    for (int t = 0; t < 20; t++) begin
      tick();
      checks++;
      if (an !== 6'd0 || dp !== 1'b0 || fs !== 1'b0 || an_n !== 6'h3f || dp_n !== 1'b1) begin
        errors++;
        $display("FAIL enable_low got an=%b dp=%b fs=%b inv=%b/%b required an=000000 dp=0 fs=0",
                 an, dp, fs, an_n, dp_n);
      end
    end
    en = 1'b1;
    remaining = 0;
    for (int t = 0; t < FRAME; t++) begin
      tick();
      checks++;
      if ({seg, dp, an, fs} !== {exp_seg, exp_dp, exp_an, exp_fs} ||
          {seg_n, dp_n, an_n} !== ~{exp_seg, exp_dp, exp_an}) begin
        errors++;
        $display("FAIL enable_resume pos=%0d got seg=%b dp=%b an=%b fs=%b required seg=%b dp=%b an=%b fs=%b",
                 m_pos, seg, dp, an, fs, exp_seg, exp_dp, exp_an, exp_fs);
      end
      if (t < RD && an == 6'b000010) remaining++;
    end
    checks++;
    if (remaining != 2 * RD - held) begin
      errors++;
      $display("FAIL enable_remaining got %0d cycles required %0d", remaining, 2 * RD - held);
    end
  endtask

  task automatic test_async_reset();
    bit first_seen;
    go_to(4 * RD + 4);
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if ({seg, dp, an, fs} !== 15'd0 || {seg_n, dp_n, an_n} !== 14'h3fff) begin
      errors++;
      $display("FAIL async_reset got seg=%b dp=%b an=%b fs=%b required all off", seg, dp, an, fs);
    end
    model_reset();
    tick();
    tick();
    reset = 1'b0;
    first_seen = 0;
    for (int t = 0; t < FRAME + 2; t++) begin
      tick();
      checks++;
      if ({seg, dp, an, fs} !== {exp_seg, exp_dp, exp_an, exp_fs}) begin
        errors++;
        $display("FAIL async_restart pos=%0d got seg=%b an=%b fs=%b required seg=%b an=%b fs=%b",
                 m_pos, seg, an, fs, exp_seg, exp_an, exp_fs);
      end
      if (!first_seen && an != 6'd0) begin
        first_seen = 1;
        checks++;
        if (an !== 6'b000001) begin
          errors++;
          $display("FAIL async_first_slot got an=%b required 000001", an);
        end
      end
    end
  endtask

  task automatic test_random();
    for (int t = 0; t < 6 * FRAME; t++) begin
      if ($urandom_range(0, 9) == 0) begin
        sec_units  = 4'($urandom_range(0, 9));
        sec_tens   = 4'($urandom_range(0, 5));
        min_units  = 4'($urandom_range(0, 15));
        min_tens   = 4'($urandom_range(0, 5));
        hour_units = 4'($urandom_range(0, 9));
        hour_tens  = 2'($urandom_range(0, 1));
      end
      en = ($urandom_range(0, 9) != 0);
      tick();
      checks++;
      if ({seg, dp, an, fs} !== {exp_seg, exp_dp, exp_an, exp_fs} ||
          {seg_n, dp_n, an_n} !== ~{exp_seg, exp_dp, exp_an} || fs_n !== exp_fs) begin
        errors++;
        $display("FAIL random pos=%0d got seg=%b dp=%b an=%b fs=%b required seg=%b dp=%b an=%b fs=%b",
                 m_pos, seg, dp, an, fs, exp_seg, exp_dp, exp_an, exp_fs);
      end
    end
    en = 1'b1;
  endtask

  initial begin
    seg_table[0] = 7'b0111111; seg_table[1] = 7'b0000110; seg_table[2] = 7'b1011011;
    seg_table[3] = 7'b1001111; seg_table[4] = 7'b1100110; seg_table[5] = 7'b1101101;
    seg_table[6] = 7'b1111101; seg_table[7] = 7'b0000111; seg_table[8] = 7'b1111111;
    seg_table[9] = 7'b1101111;
    for (int i = 10; i < 16; i++) seg_table[i] = 7'b1000000;
    model_reset();
    #1;
    test_reset();
    test_scan();
    test_leading_zero();
    test_tearing();
    test_invalid();
    test_enable();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
